// File: rtl/uart_tx_if.sv
// uart_tx_if: byte offer handshake into the UART transmitter.
//   tx_data  : byte to send, sampled when tx_valid && tx_ready
//   tx_valid : byte offer from the producer
//   tx_ready : transmitter can take a byte (holding register empty)
interface uart_tx_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready
    );
endinterface

// File: rtl/uart_tx.sv
// uart_tx: RS-232 transmitter, 8 data bits LSB first, optional parity,
// 1 or 2 stop bits, 16x tick bit timing shared with the rx receiver.
// A one-entry holding register lets frames run back to back.
//   clk      : clock
//   rst      : asynchronous active-high reset
//   bus      : slave side of uart_tx_if (tx_data/tx_valid in, tx_ready out)
//   RS232_TX : registered serial line, idle high
//   tx_busy  : registered, high while a frame is in progress
//   tx_done  : registered, one-cycle pulse after the last stop period
module uart_tx #(
    parameter logic [15:0] BPS_DR     = 16'd324,
    parameter bit          PARITY_EN  = 1'b0,
    parameter bit          PARITY_ODD = 1'b0,
    parameter int unsigned STOP_BITS  = 1
) (
    input  logic      clk,
    input  logic      rst,
    uart_tx_if.slave  bus,
    output logic      RS232_TX,
    output logic      tx_busy,
    output logic      tx_done
);

    localparam logic [3:0] TICK_LAST = 4'd15;
    localparam logic [2:0] BIT_LAST  = 3'd7;
    localparam logic       STOP_LAST = 1'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    state_t      r_state;
    logic [15:0] r_div;
    logic [3:0]  r_tick;
    logic [2:0]  r_bit_idx;
    logic        r_stop_cnt;
    logic [7:0]  r_shift;
    logic        r_parity;
    logic [7:0]  r_hold;
    logic        r_hold_full;
    logic        r_tx;
    logic        r_busy;
    logic        r_done;

    logic        w_accept;
    logic        w_tick_end;
    logic        w_bit_end;

    assign bus.tx_ready = !r_hold_full;
    assign w_accept     = bus.tx_valid && !r_hold_full;
    assign w_tick_end   = (r_div == BPS_DR);
    assign w_bit_end    = w_tick_end && (r_tick == TICK_LAST);

    assign RS232_TX = r_tx;
    assign tx_busy  = r_busy;
    assign tx_done  = r_done;

    // Bit-period timer: runs only while a frame is on the line. A bit
    // boundary wraps both counters to zero, so a back-to-back start
    // begins with a fresh period without an explicit restart.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_div  <= '0;
            r_tick <= '0;
        end else if (r_state == ST_IDLE) begin
            r_div  <= '0;
            r_tick <= '0;
        end else if (w_tick_end) begin
            r_div  <= '0;
            r_tick <= r_tick + 4'd1;
        end else begin
            r_div  <= r_div + 16'd1;
        end
    end

    // Frame FSM plus holding register. Load (clears hold_full) and accept
    // (needs hold_full clear) can never happen in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_bit_idx   <= '0;
            r_stop_cnt  <= 1'b0;
            r_shift     <= '0;
            r_parity    <= 1'b0;
            r_hold      <= '0;
            r_hold_full <= 1'b0;
            r_tx        <= 1'b1;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (r_hold_full) begin
                        r_shift     <= r_hold;
                        r_parity    <= (^r_hold) ^ PARITY_ODD;
                        r_hold_full <= 1'b0;
                        r_tx        <= 1'b0;
                        r_busy      <= 1'b1;
                        r_state     <= ST_START;
                    end
                end

                ST_START: begin
                    if (w_bit_end) begin
                        r_tx      <= r_shift[0];
                        r_bit_idx <= '0;
                        r_state   <= ST_DATA;
                    end
                end

                ST_DATA: begin
                    if (w_bit_end) begin
                        if (r_bit_idx == BIT_LAST) begin
                            if (PARITY_EN) begin
                                r_tx    <= r_parity;
                                r_state <= ST_PARITY;
                            end else begin
                                r_tx       <= 1'b1;
                                r_stop_cnt <= 1'b0;
                                r_state    <= ST_STOP;
                            end
                        end else begin
                            r_tx      <= r_shift[1];
                            r_shift   <= {1'b0, r_shift[7:1]};
                            r_bit_idx <= r_bit_idx + 3'd1;
                        end
                    end
                end

                ST_PARITY: begin
                    if (w_bit_end) begin
                        r_tx       <= 1'b1;
                        r_stop_cnt <= 1'b0;
                        r_state    <= ST_STOP;
                    end
                end

                ST_STOP: begin
                    if (w_bit_end) begin
                        if (r_stop_cnt == STOP_LAST) begin
                            r_done <= 1'b1;
                            if (r_hold_full) begin
                                // Next byte starts immediately, no idle bit.
                                r_shift     <= r_hold;
                                r_parity    <= (^r_hold) ^ PARITY_ODD;
                                r_hold_full <= 1'b0;
                                r_tx        <= 1'b0;
                                r_state     <= ST_START;
                            end else begin
                                r_tx    <= 1'b1;
                                r_busy  <= 1'b0;
                                r_state <= ST_IDLE;
                            end
                        end else begin
                            r_stop_cnt <= 1'b1;
                        end
                    end
                end

                default: begin
                    r_tx    <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase

            if (w_accept) begin
                r_hold      <= bus.tx_data;
                r_hold_full <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx with BPS_DR=1 (one bit = 32 clk cycles).
// Three instances: a = 8N1, b = 8 data + even parity + 2 stop, c = odd parity + 1 stop.
module tb_uart_tx;

    localparam int BIT       = 32;
    localparam int WAIT_MAX  = 3000;
    localparam int FRAME_MAX = 2000;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    uart_tx_if bus_a ();
    uart_tx_if bus_b ();
    uart_tx_if bus_c ();

    logic tx_a, busy_a, done_a;
    logic tx_b, busy_b, done_b;
    logic tx_c, busy_c, done_c;

    uart_tx #(.BPS_DR(16'd1)) dut_a (
        .clk(clk), .rst(rst), .bus(bus_a.slave),
        .RS232_TX(tx_a), .tx_busy(busy_a), .tx_done(done_a)
    );

    uart_tx #(.BPS_DR(16'd1), .PARITY_EN(1'b1), .PARITY_ODD(1'b0), .STOP_BITS(2)) dut_b (
        .clk(clk), .rst(rst), .bus(bus_b.slave),
        .RS232_TX(tx_b), .tx_busy(busy_b), .tx_done(done_b)
    );

    uart_tx #(.BPS_DR(16'd1), .PARITY_EN(1'b1), .PARITY_ODD(1'b1), .STOP_BITS(1)) dut_c (
        .clk(clk), .rst(rst), .bus(bus_c.slave),
        .RS232_TX(tx_c), .tx_busy(busy_c), .tx_done(done_c)
    );

    int total = 0;
    int bad   = 0;

    logic [15:0] bits1, bits2;
    int          len1, len2, gl1, gl2;
    int          cnt_done, cnt_low;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic line(input int w);
        case (w)
            0:       return tx_a;
            1:       return tx_b;
            default: return tx_c;
        endcase
    endfunction

    function automatic logic done_of(input int w);
        case (w)
            0:       return done_a;
            1:       return done_b;
            default: return done_c;
        endcase
    endfunction

    function automatic logic rdy(input int w);
        case (w)
            0:       return bus_a.tx_ready;
            1:       return bus_b.tx_ready;
            default: return bus_c.tx_ready;
        endcase
    endfunction

    task automatic drive(input int w, input logic v, input logic [7:0] d);
        case (w)
            0:       begin bus_a.tx_valid = v; bus_a.tx_data = d; end
            1:       begin bus_b.tx_valid = v; bus_b.tx_data = d; end
            default: begin bus_c.tx_valid = v; bus_c.tx_data = d; end
        endcase
    endtask

    // Offer one byte; returns 1 ns after the accepting edge.
    task automatic offer(input int w, input logic [7:0] d);
        int n;
        n = 0;
        @(negedge clk);
        while (rdy(w) !== 1'b1 && n < WAIT_MAX) begin
            @(negedge clk);
            n++;
        end
        chk("offer_ready", 32'(rdy(w)), 32'd1);
        drive(w, 1'b1, d);
        @(posedge clk);
        #1;
        drive(w, 1'b0, 8'h00);
    endtask

    // Capture one frame. Call at a negedge or between edges; n=0 is the
    // first negedge with the line low. bits[k] is the mid-bit level of bit
    // k, len is the cycle distance from the start bit to the tx_done pulse,
    // glitches counts line changes off the bit grid.
    task automatic frame(input int w, output logic [15:0] bits, output int len, output int glitches);
        int  n;
        logic prev;
        bits     = '0;
        len      = -1;
        glitches = 0;
        n        = 0;
        while (line(w) !== 1'b0 && n < WAIT_MAX) begin
            @(negedge clk);
            n++;
        end
        if (line(w) !== 1'b0) return;
        prev = 1'b0;
        for (int k = 0; k < FRAME_MAX; k++) begin
            if (k > 0 && line(w) !== prev && (k % BIT) != 0) glitches++;
            prev = line(w);
            if ((k % BIT) == BIT / 2 && (k / BIT) < 16) bits[4'(k / BIT)] = line(w);
            if (k > 0 && done_of(w) === 1'b1) begin
                len = k;
                break;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        drive(0, 1'b0, 8'h00);
        drive(1, 1'b0, 8'h00);
        drive(2, 1'b0, 8'h00);

        // Reset values
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_tx",    32'(tx_a),          32'd1);
        chk("rst_busy",  32'(busy_a),        32'd0);
        chk("rst_done",  32'(done_a),        32'd0);
        chk("rst_ready", 32'(bus_a.tx_ready), 32'd1);
        rst = 1'b0;

        // 8N1 0x55 with exact first-bit latency
        offer(0, 8'h55);
        chk("acc_ready", 32'(bus_a.tx_ready), 32'd0);
        chk("acc_tx",    32'(tx_a),           32'd1);
        chk("acc_busy",  32'(busy_a),         32'd0);
        @(posedge clk);
        #1;
        chk("e1_tx",    32'(tx_a),           32'd0);
        chk("e1_busy",  32'(busy_a),         32'd1);
        chk("e1_ready", 32'(bus_a.tx_ready), 32'd1);
        @(negedge clk);
        frame(0, bits1, len1, gl1);
        chk("f55_bits", 32'(bits1), 32'h2AA);
        chk("f55_len",  32'(len1),  32'd320);
        chk("f55_grid", 32'(gl1),   32'd0);
        chk("f55_busy_end", 32'(busy_a), 32'd0);
        chk("f55_tx_end",   32'(tx_a),   32'd1);
        @(negedge clk);
        chk("f55_done_pulse", 32'(done_a), 32'd0);

        // Back-to-back 0xA5 then 0x3C, second offered during DATA
        offer(0, 8'hA5);
        fork
            frame(0, bits1, len1, gl1);
            begin
                repeat (4 * BIT) @(negedge clk);
                offer(0, 8'h3C);
                chk("b2b_ready_acc", 32'(bus_a.tx_ready), 32'd0);
                repeat (BIT) @(negedge clk);
                chk("b2b_ready_held", 32'(bus_a.tx_ready), 32'd0);
            end
        join
        chk("fA5_bits", 32'(bits1), 32'h34A);
        chk("fA5_len",  32'(len1),  32'd320);
        chk("b2b_start_at_done", 32'(tx_a),           32'd0);
        chk("b2b_busy",          32'(busy_a),         32'd1);
        chk("b2b_ready_load",    32'(bus_a.tx_ready), 32'd1);
        frame(0, bits2, len2, gl2);
        chk("f3C_bits", 32'(bits2), 32'h278);
        chk("f3C_len",  32'(len2),  32'd320);
        chk("f3C_grid", 32'(gl1 + gl2), 32'd0);
        chk("f3C_busy_end", 32'(busy_a), 32'd0);

        // Odd parity, 0x07 -> parity bit 0
        offer(2, 8'h07);
        frame(2, bits1, len1, gl1);
        chk("odd07_bits", 32'(bits1), 32'h40E);
        chk("odd07_len",  32'(len1),  32'd352);
        chk("odd07_busy", 32'(busy_c), 32'd0);

        // Even parity + 2 stop, 0x07 -> parity bit 1
        offer(1, 8'h07);
        frame(1, bits1, len1, gl1);
        chk("even07_bits", 32'(bits1), 32'hE0E);
        chk("even07_len",  32'(len1),  32'd384);

        // Even parity + 2 stop, 0xFF -> parity bit 0, two high stop periods
        offer(1, 8'hFF);
        frame(1, bits1, len1, gl1);
        chk("evenFF_bits", 32'(bits1), 32'hDFE);
        chk("evenFF_len",  32'(len1),  32'd384);
        chk("evenFF_grid", 32'(gl1),   32'd0);
        chk("evenFF_busy", 32'(busy_b), 32'd0);

        // Async reset mid-DATA of 0x00
        offer(0, 8'h00);
        repeat (3 * BIT) @(negedge clk);
        chk("mid_data_low", 32'(tx_a),   32'd0);
        chk("mid_data_busy", 32'(busy_a), 32'd1);
        #3 rst = 1'b1;
        #1;
        chk("arst_tx",    32'(tx_a),           32'd1);
        chk("arst_busy",  32'(busy_a),         32'd0);
        chk("arst_ready", 32'(bus_a.tx_ready), 32'd1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        cnt_done = 0;
        cnt_low  = 0;
        for (int k = 0; k < 12 * BIT; k++) begin
            @(negedge clk);
            if (done_a === 1'b1) cnt_done++;
            if (tx_a !== 1'b1) cnt_low++;
        end
        chk("arst_no_done", 32'(cnt_done), 32'd0);
        chk("arst_idle",    32'(cnt_low),  32'd0);

        // Recovery send 0x81
        offer(0, 8'h81);
        frame(0, bits1, len1, gl1);
        chk("f81_bits", 32'(bits1), 32'h302);
        chk("f81_len",  32'(len1),  32'd320);
        chk("f81_busy", 32'(busy_a), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
